bus_port_fifo: RTL

BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

---
 rtl/bus_port_fifo.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bus_port_fifo.sv
// Bus port with a host-to-bus TX FIFO and an address-filtered bus-to-host RX FIFO,
// plus drop counters, a sticky underflow flag and a TX stall watchdog.
module bus_port_fifo #(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned depth     = 8,
    parameter logic [7:0]  id        = 8'h00,
    parameter logic [7:0]  broadcast = {8{1'b1}},
    parameter int unsigned timeout   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_rd,
    output logic [7:0]         ovf_cnt,
    output logic [7:0]         rx_drop_cnt,
    output logic               unf,
    output logic               stall
);
    localparam int unsigned AW = $clog2(depth);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t        PTR_ONE = ptr_t'(1);
    localparam logic [15:0] TMO     = 16'(timeout);

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];

    ptr_t        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    ptr_t        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [7:0]  ovf_q, ovf_d, drop_q, drop_d;
    logic [15:0] wd_q, wd_d;
    logic        unf_q, unf_d, stall_q, stall_d;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_wr_ok, tx_rd_ok, rx_wr_ok, rx_rd_ok, rx_addr_ok;

    // Extra pointer MSB separates the full and empty cases when the index bits match.
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

    assign rx_addr_ok = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast);

    // A read that frees a slot in the same edge lets a write into a full FIFO.
    assign tx_rd_ok = pop && !tx_empty;
    assign tx_wr_ok = wr_en && (!tx_full || tx_rd_ok);
    assign rx_rd_ok = rx_rd && !rx_empty;
    assign rx_wr_ok = push && rx_addr_ok && (!rx_full || rx_rd_ok);

    always_comb begin
        tx_wr_d = tx_wr_ok ? tx_wr_q + PTR_ONE : tx_wr_q;
        tx_rd_d = tx_rd_ok ? tx_rd_q + PTR_ONE : tx_rd_q;
        rx_wr_d = rx_wr_ok ? rx_wr_q + PTR_ONE : rx_wr_q;
        rx_rd_d = rx_rd_ok ? rx_rd_q + PTR_ONE : rx_rd_q;

        ovf_d = ovf_q;
        if (wr_en && !tx_wr_ok && ovf_q != 8'hFF) begin
            ovf_d = ovf_q + 8'd1;
        end
        drop_d = drop_q;
        if (push && rx_addr_ok && !rx_wr_ok && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        unf_d = unf_q | (pop && tx_empty) | (rx_rd && rx_empty);

        wd_d = wd_q;
        if (tx_empty || pop) begin
            wd_d = '0;
        end else if (wd_q != TMO) begin
            wd_d = wd_q + 16'd1;
        end
        stall_d = stall_q | (wd_d == TMO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            rx_wr_q <= '0;
            rx_rd_q <= '0;
            ovf_q   <= '0;
            drop_q  <= '0;
            wd_q    <= '0;
            unf_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            tx_wr_q <= tx_wr_d;
            tx_rd_q <= tx_rd_d;
            rx_wr_q <= rx_wr_d;
            rx_rd_q <= rx_rd_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            wd_q    <= wd_d;
            unf_q   <= unf_d;
            stall_q <= stall_d;
        end
    end

    // Storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (tx_wr_ok) begin
            tx_mem[tx_wr_q[AW-1:0]] <= wr_data;
        end
        if (rx_wr_ok) begin
            rx_mem[rx_wr_q[AW-1:0]] <= D_push;
        end
    end

    assign full        = tx_full;
    assign pndng       = !tx_empty;
    assign D_pop       = tx_mem[tx_rd_q[AW-1:0]];
    assign rx_valid    = !rx_empty;
    assign rx_data     = rx_mem[rx_rd_q[AW-1:0]];
    assign ovf_cnt     = ovf_q;
    assign rx_drop_cnt = drop_q;
    assign unf         = unf_q;
    assign stall       = stall_q;
endmodule
